// File: rtl/datapath_if.sv
// Control word, decoded instruction fields and result outputs of the execution datapath.
interface datapath_if;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic [1:0]  vsel;
  logic        loada;
  logic        loadb;
  logic        asel;
  logic        bsel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic        loadc;
  logic        loads;
  logic [15:0] sximm8;
  logic [15:0] sximm5;
  logic [15:0] mdata;
  logic [7:0]  PC;
  logic [15:0] datapath_out;
  logic [2:0]  Z_out;

  // Controller side: drives the control word and operands, observes results.
  modport master (
    output readnum, writenum, write, vsel, loada, loadb, asel, bsel,
    output shift, ALUop, loadc, loads, sximm8, sximm5, mdata, PC,
    input  datapath_out, Z_out
  );

  // Datapath side.
  modport slave (
    input  readnum, writenum, write, vsel, loada, loadb, asel, bsel,
    input  shift, ALUop, loadc, loads, sximm8, sximm5, mdata, PC,
    output datapath_out, Z_out
  );
endinterface

// File: rtl/datapath.sv
// Sixteen-bit execution datapath: 8-entry register file, A/B operand registers,
// shifter, ALU, result register C and {V,N,Z} status register.
module datapath (
  input  logic       clk,
  input  logic       reset,
  datapath_if.slave  bus
);

  logic [15:0] regs_q [8];
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [15:0] c_q;
  logic [2:0]  status_q;

  logic [15:0] read_data;
  logic [15:0] write_data;
  logic [15:0] shift_out;
  logic [15:0] ain;
  logic [15:0] bin;
  logic [15:0] alu_out;
  logic        overflow;
  logic [2:0]  flags;

  // No bypass: reads always see the pre-edge register contents.
  assign read_data = regs_q[bus.readnum];

  // Write-back source select.
  always_comb begin
    write_data = c_q;
    unique case (bus.vsel)
      2'b00: write_data = c_q;
      2'b01: write_data = {8'b0, bus.PC};
      2'b10: write_data = bus.sximm8;
      2'b11: write_data = bus.mdata;
    endcase
  end

  // Single-bit shifter on the B operand.
  always_comb begin
    shift_out = b_q;
    unique case (bus.shift)
      2'b00: shift_out = b_q;
      2'b01: shift_out = {b_q[14:0], 1'b0};
      2'b10: shift_out = {1'b0, b_q[15:1]};
      2'b11: shift_out = {b_q[15], b_q[15:1]};
    endcase
  end

  assign ain = bus.asel ? 16'h0000 : a_q;
  assign bin = bus.bsel ? bus.sximm5 : shift_out;

  // ALU and signed-overflow detection.
  always_comb begin
    alu_out  = '0;
    overflow = 1'b0;
    unique case (bus.ALUop)
      2'b00: begin
        alu_out  = ain + bin;
        overflow = (ain[15] == bin[15]) && (alu_out[15] != ain[15]);
      end
      2'b01: begin
        alu_out  = ain - bin;
        overflow = (ain[15] != bin[15]) && (alu_out[15] != ain[15]);
      end
      2'b10: alu_out = ain & bin;
      2'b11: alu_out = ~bin;
    endcase
  end

  assign flags = {overflow, alu_out[15], (alu_out == 16'h0000)};

  // Register file write port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= '0;
      end
    end else if (bus.write) begin
      regs_q[bus.writenum] <= write_data;
    end
  end

  // Operand, result and status registers; each enable is independent.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      status_q <= '0;
    end else begin
      if (bus.loada) a_q      <= read_data;
      if (bus.loadb) b_q      <= read_data;
      if (bus.loadc) c_q      <= alu_out;
      if (bus.loads) status_q <= flags;
    end
  end

  assign bus.datapath_out = c_q;
  assign bus.Z_out        = status_q;

endmodule
